// File: rtl/igniter_array.sv
// igniter_array
//   Bank of NUM_CH independent igniter positioners sharing one step divider.
//   Each channel holds a target and a position; accepted move commands shift
//   the target by a signed delta (relative to the target, so queued moves
//   accumulate) and every step tick moves each position one unit toward its
//   target.
//
//   Build option: define IGN_WRAP_EN for modular (wrap-around) positions with
//   shortest-path stepping; left undefined, targets saturate to the position
//   range.
//
// Parameters
//   NUM_CH   : number of channels (1..16)
//   POS_W    : position width, range 0..2^POS_W-1
//   DELTA_W  : width of the two's-complement move delta
//   STEP_DIV : sys_clk cycles per motion step (>=1)
//
// Ports
//   sys_clk    in   clock, rising edge
//   clr        in   synchronous active-high reset
//   cmd_valid  in   move command present
//   cmd_ready  out  command accepted this cycle (= ~clr)
//   cmd_ch     in   target channel index
//   cmd_delta  in   signed relative move
//   position_q out  packed positions, channel k at [k*POS_W +: POS_W]
//   busy_q     out  per channel, position differs from target
//   done_q     out  per channel, one-cycle pulse when a step reaches target
//   sat_q      out  one-cycle pulse after an accepted command was clipped
//   err_q      out  one-cycle pulse after a command addressed cmd_ch >= NUM_CH
module igniter_array #(
    parameter int NUM_CH   = 4,
    parameter int POS_W    = 3,
    parameter int DELTA_W  = 4,
    parameter int STEP_DIV = 4
) (
    input  logic                                       sys_clk,
    input  logic                                       clr,
    input  logic                                       cmd_valid,
    output logic                                       cmd_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cmd_ch,
    input  logic [DELTA_W-1:0]                         cmd_delta,
    output logic [NUM_CH*POS_W-1:0]                    position_q,
    output logic [NUM_CH-1:0]                          busy_q,
    output logic [NUM_CH-1:0]                          done_q,
    output logic                                       sat_q,
    output logic                                       err_q
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EXT_W = ((POS_W > DELTA_W) ? POS_W : DELTA_W) + 2;
    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);
`ifdef IGN_WRAP_EN
    localparam logic [POS_W-1:0] HALF = POS_W'(1) << (POS_W - 1);
`endif

    logic [POS_W-1:0]  pos_q [NUM_CH];
    logic [POS_W-1:0]  pos_d [NUM_CH];
    logic [POS_W-1:0]  tgt_q [NUM_CH];
    logic [POS_W-1:0]  tgt_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] busy_d, done_d, stepping;
    logic              sat_d, err_d;

    logic              tick, ch_ok, accept, clipped;
    logic [POS_W-1:0]  tgt_sel, tgt_new;
    logic [EXT_W-1:0]  sum;

    assign cmd_ready = ~clr;
    assign accept    = cmd_valid & ~clr;
    assign tick      = (cnt_q == CNT_MAX);
    assign ch_ok     = ({1'b0, cmd_ch} < (CH_W + 1)'(NUM_CH));

    // Direction of the next step: saturating mode simply compares; wrap
    // mode takes the shorter way round the ring, ties going up.
    function automatic logic step_up(input logic [POS_W-1:0] pos,
                                     input logic [POS_W-1:0] tgt);
`ifdef IGN_WRAP_EN
        logic [POS_W-1:0] diff;
        diff = tgt - pos;
        return (diff <= HALF);
`else
        return (tgt > pos);
`endif
    endfunction

    // New target for the addressed channel. The sum is formed with two
    // spare bits so both underflow (sign bit) and overflow are visible.
    always_comb begin
        tgt_sel = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (cmd_ch == CH_W'(k)) tgt_sel = tgt_q[k];
        end
        sum = {{(EXT_W - POS_W){1'b0}}, tgt_sel}
            + {{(EXT_W - DELTA_W){cmd_delta[DELTA_W-1]}}, cmd_delta};
`ifdef IGN_WRAP_EN
        tgt_new = sum[POS_W-1:0];
        clipped = 1'b0;
`else
        if (sum[EXT_W-1]) begin
            tgt_new = '0;
            clipped = 1'b1;
        end else if (|sum[EXT_W-2:POS_W]) begin
            tgt_new = '1;
            clipped = 1'b1;
        end else begin
            tgt_new = sum[POS_W-1:0];
            clipped = 1'b0;
        end
`endif
    end

    // Per-channel next state. The step is decided from the pre-update
    // target, so a coinciding command only steers from the following tick.
    always_comb begin
        stepping = '0;
        busy_d   = '0;
        done_d   = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            pos_d[k]    = pos_q[k];
            tgt_d[k]    = tgt_q[k];
            stepping[k] = tick && (pos_q[k] != tgt_q[k]);
            if (stepping[k]) begin
                pos_d[k] = step_up(pos_q[k], tgt_q[k]) ? pos_q[k] + POS_W'(1)
                                                       : pos_q[k] - POS_W'(1);
            end
            if (accept && ch_ok && (cmd_ch == CH_W'(k))) tgt_d[k] = tgt_new;
            busy_d[k] = (pos_d[k] != tgt_d[k]);
            // Only a step can complete a move; retargeting onto the current
            // position is silent.
            done_d[k] = stepping[k] && (pos_d[k] == tgt_d[k]);
        end
        sat_d = accept & ch_ok & clipped;
        err_d = accept & ~ch_ok;
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (clr) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                pos_q[k] <= '0;
                tgt_q[k] <= '0;
            end
            cnt_q  <= '0;
            busy_q <= '0;
            done_q <= '0;
            sat_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                pos_q[k] <= pos_d[k];
                tgt_q[k] <= tgt_d[k];
            end
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            sat_q  <= sat_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        position_q = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            position_q[k*POS_W +: POS_W] = pos_q[k];
        end
    end

endmodule

// File: tb/tb_igniter_array.sv
module tb_igniter_array;

    localparam int NCH = 4;
    localparam int PW  = 3;
    localparam int DW  = 4;
    localparam int SD  = 4;
    localparam int PMAX = (1 << PW) - 1;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Main instance (NUM_CH = 4)
    logic              clr, cmd_valid, cmd_ready, sat_q, err_q;
    logic [1:0]        cmd_ch;
    logic [DW-1:0]     cmd_delta;
    logic [NCH*PW-1:0] position_q;
    logic [NCH-1:0]    busy_q, done_q;

    // Second instance (NUM_CH = 3) for out-of-range channel addressing
    logic              clr3, v3, rdy3, sat3, err3;
    logic [1:0]        ch3;
    logic [DW-1:0]     d3;
    logic [3*PW-1:0]   pos3;
    logic [2:0]        busy3, done3;

    igniter_array #(.NUM_CH(NCH), .POS_W(PW), .DELTA_W(DW), .STEP_DIV(SD)) dut (
        .sys_clk(sys_clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_delta(cmd_delta), .position_q(position_q),
        .busy_q(busy_q), .done_q(done_q), .sat_q(sat_q), .err_q(err_q)
    );

    igniter_array #(.NUM_CH(3), .POS_W(PW), .DELTA_W(DW), .STEP_DIV(SD)) dut3 (
        .sys_clk(sys_clk), .clr(clr3), .cmd_valid(v3), .cmd_ready(rdy3),
        .cmd_ch(ch3), .cmd_delta(d3), .position_q(pos3),
        .busy_q(busy3), .done_q(done3), .sat_q(sat3), .err_q(err3)
    );

    typedef struct packed {
        logic [NCH*PW-1:0] pos;
        logic [NCH-1:0]    busy;
        logic [NCH-1:0]    done;
        logic              sat;
        logic              err;
    } exp_t;

    exp_t q[$];
    int   mpos [NCH];
    int   mtgt [NCH];
    int   mcnt;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: advance one clock with the given inputs and push the
    // outputs expected after the edge.
    task automatic model(input logic c, input logic v, input int ch, input int d);
        exp_t e;
        bit   tk;
        bit   stp [NCH];
        int   nt, diff;
        e = '0;
        if (c) begin
            for (int k = 0; k < NCH; k++) begin
                mpos[k] = 0;
                mtgt[k] = 0;
            end
            mcnt = 0;
        end else begin
            tk   = (mcnt == SD - 1);
            mcnt = tk ? 0 : mcnt + 1;
            for (int k = 0; k < NCH; k++) begin
                stp[k] = tk && (mpos[k] != mtgt[k]);
                if (stp[k]) begin
`ifdef IGN_WRAP_EN
                    diff    = (mtgt[k] - mpos[k] + PMAX + 1) % (PMAX + 1);
                    mpos[k] = (mpos[k] + ((diff <= (PMAX + 1) / 2) ? 1 : -1) + PMAX + 1) % (PMAX + 1);
`else
                    mpos[k] = mpos[k] + ((mtgt[k] > mpos[k]) ? 1 : -1);
`endif
                end
            end
            if (v) begin
                nt = mtgt[ch] + d;
`ifdef IGN_WRAP_EN
                nt = ((nt % (PMAX + 1)) + PMAX + 1) % (PMAX + 1);
`else
                if (nt < 0) begin nt = 0; e.sat = 1'b1; end
                if (nt > PMAX) begin nt = PMAX; e.sat = 1'b1; end
`endif
                mtgt[ch] = nt;
            end
            for (int k = 0; k < NCH; k++) begin
                e.done[k] = stp[k] && (mpos[k] == mtgt[k]);
                e.busy[k] = (mpos[k] != mtgt[k]);
                e.pos[k*PW +: PW] = PW'(mpos[k]);
            end
        end
        q.push_back(e);
    endtask

    task automatic cyc(input logic c, input logic v, input int ch, input int d);
        exp_t e;
        clr       = c;
        cmd_valid = v;
        cmd_ch    = 2'(ch);
        cmd_delta = DW'(d);
        #1 chk("cmd_ready", 32'(cmd_ready), 32'(!c));
        model(c, v, ch, d);
        @(posedge sys_clk);
        #1;
        e = q.pop_front();
        chk("position", 32'(position_q), 32'(e.pos));
        chk("busy", 32'(busy_q), 32'(e.busy));
        chk("done", 32'(done_q), 32'(e.done));
        chk("sat", 32'(sat_q), 32'(e.sat));
        chk("err", 32'(err_q), 32'(e.err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0);
    endtask

    task automatic cyc3(input logic c, input logic v, input int ch, input int d);
        clr3 = c;
        v3   = v;
        ch3  = 2'(ch);
        d3   = DW'(d);
        #1 chk("ready3", 32'(rdy3), 32'(!c));
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clr = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_delta = '0;
        clr3 = 1'b1; v3 = 1'b0; ch3 = '0; d3 = '0;
        @(posedge sys_clk);
        #1;

        // Reset state
        cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 0, 0);

        // ch0 +3: busy next cycle, three steps, single done pulse
        cyc(1'b0, 1'b1, 0, 3);
        idle(16);

        // ch1 +6 then -5: accumulates to target 1
        cyc(1'b0, 1'b1, 1, 6);
        cyc(1'b0, 1'b1, 1, -5);
        idle(12);

        // ch2 +7 then +3: second command clips at the top
        cyc(1'b0, 1'b1, 2, 7);
        cyc(1'b0, 1'b1, 2, 3);
        idle(34);

        // ch3 -2 from 0: clips at the bottom
        cyc(1'b0, 1'b1, 3, -2);
        idle(10);

        // zero delta is a no-op
        cyc(1'b0, 1'b1, 1, 0);
        idle(4);

        // mixed traffic across channels
        for (int i = 0; i < 60; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 15)) - 8);
        end
        idle(40);

        // clr mid-move with a command present
        cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 0, 5);
        n = 0;
        while (mpos[0] != 2 && n < 40) begin
            idle(1);
            n++;
        end
        chk("pos_before_clr", 32'(position_q[PW-1:0]), 32'd2);
        chk("busy_before_clr", 32'(busy_q[0]), 32'd1);
        cyc(1'b1, 1'b1, 0, 1);
        idle(14);

        // NUM_CH = 3 instance: cmd_ch = 3 is rejected
        cyc3(1'b1, 1'b0, 0, 0);
        chk("n3_reset_pos", 32'(pos3), 32'd0);
        chk("n3_reset_err", 32'(err3), 32'd0);
        cyc3(1'b0, 1'b1, 2, 2);
        for (int i = 0; i < 12; i++) cyc3(1'b0, 1'b0, 0, 0);
        chk("n3_pos_setup", 32'(pos3), 32'h080);
        chk("n3_busy_setup", 32'(busy3), 32'd0);
        cyc3(1'b0, 1'b1, 3, 1);
        chk("n3_err_pulse", 32'(err3), 32'd1);
        chk("n3_err_pos", 32'(pos3), 32'h080);
        chk("n3_err_busy", 32'(busy3), 32'd0);
        chk("n3_err_sat", 32'(sat3), 32'd0);
        cyc3(1'b0, 1'b0, 0, 0);
        chk("n3_err_clear", 32'(err3), 32'd0);
        for (int i = 0; i < 12; i++) begin
            cyc3(1'b0, 1'b0, 0, 0);
            chk("n3_hold_pos", 32'(pos3), 32'h080);
            chk("n3_hold_busy", 32'(busy3), 32'd0);
            chk("n3_hold_done", 32'(done3), 32'd0);
            chk("n3_hold_err", 32'(err3), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
